// File: rtl/alu_issue_ctrl.sv
// Issue/control stage for the datapath ALU: decodes ALUOp/funct, registers operands, captures result. Mult path under ALU_ISSUE_MULT_EN.
// Latency: accept at edge N -> rsp_valid_o from N+2 (mult: N+MUL_LAT+1); one request in flight at a time.
// Backpressure: req_ready_o only in IDLE; response held stable in RESP until rsp_ready_i.
module alu_issue_ctrl #(
    parameter int unsigned MUL_LAT = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [2:0]  aluop_i,
    input  logic [5:0]  funct_i,
    input  logic [31:0] src_1_i,
    input  logic [31:0] src_2_i,
    output logic [31:0] alu_src_1_o,
    output logic [31:0] alu_src_2_o,
    output logic [3:0]  alu_ctrl_o,
    input  logic [31:0] alu_result_i,
    input  logic        alu_zero_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_result_o,
    output logic        rsp_zero_o,
    output logic        rsp_illegal_o
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] EXEC  = 2'd1;
    localparam logic [1:0] MWAIT = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    localparam logic [3:0] CODE_IDLE = 4'd15;
    localparam logic [3:0] CODE_MUL  = 4'd10;

    if (MUL_LAT < 1 || MUL_LAT > 15) begin : g_bad_mul_lat
        $error("alu_issue_ctrl: MUL_LAT must be in 1..15");
    end

    typedef struct packed {
        logic [31:0] result;
        logic        zero;
        logic        illegal;
    } rsp_t;

    logic [1:0] state;
    logic [3:0] dec_code;
    logic       dec_illegal;
    logic       illegal_q;
    logic       go_mwait;
    logic       mwait_done;
    rsp_t       rsp_q;
    rsp_t       rsp_cap;

    always_comb begin
        dec_code    = CODE_IDLE;
        dec_illegal = 1'b0;
        case (aluop_i)
            3'b000: dec_code = 4'd2;
            3'b001: dec_code = 4'd6;
            3'b011: dec_code = 4'd0;
            3'b100: dec_code = 4'd1;
            3'b101: dec_code = 4'd7;
            3'b010: begin
                case (funct_i)
                    6'h20: dec_code = 4'd2;
                    6'h22: dec_code = 4'd6;
                    6'h24: dec_code = 4'd0;
                    6'h25: dec_code = 4'd1;
                    6'h27: dec_code = 4'd12;
                    6'h2a: dec_code = 4'd7;
`ifdef ALU_ISSUE_MULT_EN
                    6'h18: dec_code = CODE_MUL;
`endif
                    default: dec_illegal = 1'b1;
                endcase
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    // Illegal requests report a fixed zero result regardless of what the ALU drives.
    always_comb begin
        if (illegal_q) begin
            rsp_cap = '{result: 32'd0, zero: 1'b1, illegal: 1'b1};
        end else begin
            rsp_cap = '{result: alu_result_i, zero: alu_zero_i, illegal: 1'b0};
        end
    end

`ifdef ALU_ISSUE_MULT_EN
    logic [3:0] mul_cnt;

    // The held control code identifies a multiply, so no separate op flag is kept.
    assign go_mwait   = (alu_ctrl_o == CODE_MUL) && (MUL_LAT > 1);
    assign mwait_done = (mul_cnt == 4'd0);

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            mul_cnt <= 4'd0;
        end else if (state == EXEC) begin
            mul_cnt <= 4'(MUL_LAT - 2);
        end else if (state == MWAIT && mul_cnt != 4'd0) begin
            mul_cnt <= mul_cnt - 4'd1;
        end
    end
`else
    assign go_mwait   = 1'b0;
    assign mwait_done = 1'b1;
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state       <= IDLE;
            alu_src_1_o <= 32'd0;
            alu_src_2_o <= 32'd0;
            alu_ctrl_o  <= CODE_IDLE;
            illegal_q   <= 1'b0;
            rsp_q       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid_i) begin
                        alu_src_1_o <= src_1_i;
                        alu_src_2_o <= src_2_i;
                        alu_ctrl_o  <= dec_illegal ? CODE_IDLE : dec_code;
                        illegal_q   <= dec_illegal;
                        state       <= EXEC;
                    end
                end
                EXEC: begin
                    if (go_mwait) begin
                        state <= MWAIT;
                    end else begin
                        rsp_q      <= rsp_cap;
                        alu_ctrl_o <= CODE_IDLE;
                        state      <= RESP;
                    end
                end
                MWAIT: begin
                    if (mwait_done) begin
                        rsp_q      <= rsp_cap;
                        alu_ctrl_o <= CODE_IDLE;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign req_ready_o   = (state == IDLE);
    assign rsp_valid_o   = (state == RESP);
    assign rsp_result_o  = rsp_q.result;
    assign rsp_zero_o    = rsp_q.zero;
    assign rsp_illegal_o = rsp_q.illegal;

endmodule
